// File: rtl/amo_ctrl.sv
// RV32A atomic sequencer: LR.W / SC.W / AMO read-modify-write over a single-outstanding
// memory request port, with the LR reservation held locally.
module amo_ctrl #(
  parameter int XLEN      = 32,
  parameter int AMOOP_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 amo_valid_i,
  input  logic [AMOOP_LEN-1:0] amo_op_i,
  input  logic [XLEN-1:0]      amo_addr_i,
  input  logic [XLEN-1:0]      amo_rs2_i,
  input  logic                 kill_i,
  input  logic                 snoop_st_valid_i,
  input  logic [XLEN-1:0]      snoop_st_addr_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic                 mem_req_we_o,
  output logic [XLEN-1:0]      mem_req_addr_o,
  output logic [XLEN-1:0]      mem_req_wdata_o,
  input  logic                 mem_resp_valid_i,
  input  logic [XLEN-1:0]      mem_resp_rdata_i,
  output logic [XLEN-1:0]      amo_result_o,
  output logic                 amo_done_o,
  output logic                 busy_o
);

  localparam logic [AMOOP_LEN-1:0] AMOOP_LR   = AMOOP_LEN'(0);
  localparam logic [AMOOP_LEN-1:0] AMOOP_SC   = AMOOP_LEN'(1);
  localparam logic [AMOOP_LEN-1:0] AMOOP_SWAP = AMOOP_LEN'(2);
  localparam logic [AMOOP_LEN-1:0] AMOOP_ADD  = AMOOP_LEN'(3);
  localparam logic [AMOOP_LEN-1:0] AMOOP_XOR  = AMOOP_LEN'(4);
  localparam logic [AMOOP_LEN-1:0] AMOOP_AND  = AMOOP_LEN'(5);
  localparam logic [AMOOP_LEN-1:0] AMOOP_OR   = AMOOP_LEN'(6);
  localparam logic [AMOOP_LEN-1:0] AMOOP_MIN  = AMOOP_LEN'(7);
  localparam logic [AMOOP_LEN-1:0] AMOOP_MAX  = AMOOP_LEN'(8);
  localparam logic [AMOOP_LEN-1:0] AMOOP_MINU = AMOOP_LEN'(9);
  localparam logic [AMOOP_LEN-1:0] AMOOP_MAXU = AMOOP_LEN'(10);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]           state;
  logic [AMOOP_LEN-1:0] op;
  logic [XLEN-1:2]      word;
  logic [XLEN-1:0]      rs2;
  logic [XLEN-1:0]      wdata;
  logic [XLEN-1:0]      result;
  logic                 killed;
  logic                 resv_valid;
  logic [XLEN-1:2]      resv_addr;
  logic [XLEN-1:0]      amo_new;
  logic                 sc_hit;
  logic                 snoop_hit;
  logic                 finish_killed;
  logic                 unused_low_bits;

  // Byte offsets are irrelevant: addresses are word-aligned and reservations are per word.
  assign unused_low_bits = ^{amo_addr_i[1:0], snoop_st_addr_i[1:0]};

  assign sc_hit        = resv_valid && (resv_addr == amo_addr_i[XLEN-1:2]);
  assign snoop_hit     = snoop_st_valid_i && (snoop_st_addr_i[XLEN-1:2] == resv_addr);
  assign finish_killed = killed || kill_i;

  always_comb begin
    amo_new = rs2;
    case (op)
      AMOOP_SWAP: amo_new = rs2;
      AMOOP_ADD:  amo_new = mem_resp_rdata_i + rs2;
      AMOOP_XOR:  amo_new = mem_resp_rdata_i ^ rs2;
      AMOOP_AND:  amo_new = mem_resp_rdata_i & rs2;
      AMOOP_OR:   amo_new = mem_resp_rdata_i | rs2;
      AMOOP_MIN:  amo_new = ($signed(mem_resp_rdata_i) < $signed(rs2)) ? mem_resp_rdata_i : rs2;
      AMOOP_MAX:  amo_new = ($signed(mem_resp_rdata_i) > $signed(rs2)) ? mem_resp_rdata_i : rs2;
      AMOOP_MINU: amo_new = (mem_resp_rdata_i < rs2) ? mem_resp_rdata_i : rs2;
      AMOOP_MAXU: amo_new = (mem_resp_rdata_i > rs2) ? mem_resp_rdata_i : rs2;
      default:    amo_new = rs2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op         <= '0;
      word       <= '0;
      rs2        <= '0;
      wdata      <= '0;
      result     <= '0;
      killed     <= 1'b0;
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else begin
      if (kill_i || snoop_hit) resv_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (amo_valid_i && !kill_i) begin
            op     <= amo_op_i;
            word   <= amo_addr_i[XLEN-1:2];
            rs2    <= amo_rs2_i;
            killed <= 1'b0;
            if (amo_op_i == AMOOP_SC) begin
              resv_valid <= 1'b0;
              if (sc_hit) begin
                wdata  <= amo_rs2_i;
                result <= '0;
                state  <= S_WR_REQ;
              end else begin
                result <= XLEN'(1);
                state  <= S_DONE;
              end
            end else begin
              state <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: begin
          // Acceptance takes priority: a kill on the accepting edge must still finish the sequence.
          if (mem_req_ready_i) begin
            state <= S_RD_WAIT;
            if (kill_i) killed <= 1'b1;
          end else if (kill_i) begin
            state <= S_IDLE;
          end
        end
        S_RD_WAIT: begin
          if (kill_i) killed <= 1'b1;
          if (mem_resp_valid_i) begin
            result <= mem_resp_rdata_i;
            if (op == AMOOP_LR) begin
              if (!finish_killed) begin
                resv_valid <= 1'b1;
                resv_addr  <= word;
              end
              state <= finish_killed ? S_IDLE : S_DONE;
            end else begin
              wdata <= amo_new;
              state <= S_WR_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (kill_i) killed <= 1'b1;
          if (mem_req_ready_i) state <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (kill_i) killed <= 1'b1;
          if (mem_resp_valid_i) state <= finish_killed ? S_IDLE : S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_req_valid_o = (state == S_RD_REQ) || (state == S_WR_REQ);
  assign mem_req_we_o    = (state == S_WR_REQ);
  assign mem_req_addr_o  = {word, 2'b00};
  assign mem_req_wdata_o = wdata;
  assign amo_result_o    = result;
  assign amo_done_o      = (state == S_DONE);
  assign busy_o          = (state != S_IDLE);

endmodule
